// File: rtl/retire_trace_buf.sv
// Retire-event capture: statistics counters plus a trace-record FIFO drained over valid/ready.
// Optional macro RETIRE_TRACE_CACHE_STATS_EN enables the four cache request/hit counters.
module retire_trace_buf #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             reg_wr_i,
  input  logic [2:0]       wr_reg_i,
  input  logic [15:0]      wr_data_i,
  input  logic             mem_rd_i,
  input  logic             mem_wr_i,
  input  logic [15:0]      mem_addr_i,
  input  logic [15:0]      mem_data_i,
  input  logic             halt_i,
  input  logic             ic_req_i,
  input  logic             ic_hit_i,
  input  logic             dc_req_i,
  input  logic             dc_hit_i,
  input  logic             rd_ready_i,
  output logic             rd_valid_o,
  output logic [54:0]      rd_rec_o,
  output logic [CNT_W-1:0] cyc_cnt_o,
  output logic [CNT_W-1:0] inst_cnt_o,
  output logic [CNT_W-1:0] ic_req_cnt_o,
  output logic [CNT_W-1:0] ic_hit_cnt_o,
  output logic [CNT_W-1:0] dc_req_cnt_o,
  output logic [CNT_W-1:0] dc_hit_cnt_o,
  output logic             halted_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic        halt;
    logic        st;
    logic        ld;
    logic        rw;
    logic [2:0]  rg;
    logic [15:0] wr_data;
    logic [15:0] addr;
    logic [15:0] mem_data;
  } rec_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  rec_t            mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, inst_q, inst_d;
  logic            halted_q, halted_d, overflow_q, overflow_d;

  logic full, empty, pop, push_req, push, active, retire;
  rec_t new_rec;

  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign active   = ~halted_q;
  assign retire   = halt_i | reg_wr_i | mem_wr_i;
  assign pop      = ~empty & rd_ready_i;
  assign push_req = active & (reg_wr_i | mem_rd_i | mem_wr_i | halt_i);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);

  always_comb begin
    new_rec          = '0;
    new_rec.halt     = halt_i;
    new_rec.st       = mem_wr_i;
    new_rec.ld       = mem_rd_i;
    new_rec.rw       = reg_wr_i;
    new_rec.rg       = reg_wr_i ? wr_reg_i  : 3'd0;
    new_rec.wr_data  = reg_wr_i ? wr_data_i : 16'd0;
    new_rec.addr     = (mem_rd_i | mem_wr_i) ? mem_addr_i : 16'd0;
    new_rec.mem_data = (mem_rd_i | mem_wr_i) ? mem_data_i : 16'd0;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cyc_d      = cyc_q;
    inst_d     = inst_q;
    halted_d   = halted_q;
    overflow_d = overflow_q;
    if (clr_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cyc_d      = '0;
      inst_d     = '0;
      halted_d   = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (push_req & full & ~pop) overflow_d = 1'b1;
      if (active) begin
        cyc_d = sat_inc(cyc_q);
        if (retire) inst_d = sat_inc(inst_q);
        if (halt_i) halted_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cyc_q      <= '0;
      inst_q     <= '0;
      halted_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cyc_q      <= cyc_d;
      inst_q     <= inst_d;
      halted_q   <= halted_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: record storage has no reset; the pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push & ~clr_i) mem_q[wr_ptr_q[AW-1:0]] <= new_rec;
  end

  assign rd_valid_o = ~empty;
  assign rd_rec_o   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign cyc_cnt_o  = cyc_q;
  assign inst_cnt_o = inst_q;
  assign halted_o   = halted_q;
  assign overflow_o = overflow_q;

`ifdef RETIRE_TRACE_CACHE_STATS_EN
  logic [CNT_W-1:0] ic_req_q, ic_req_d, ic_hit_q, ic_hit_d;
  logic [CNT_W-1:0] dc_req_q, dc_req_d, dc_hit_q, dc_hit_d;

  always_comb begin
    ic_req_d = ic_req_q;
    ic_hit_d = ic_hit_q;
    dc_req_d = dc_req_q;
    dc_hit_d = dc_hit_q;
    if (clr_i) begin
      ic_req_d = '0;
      ic_hit_d = '0;
      dc_req_d = '0;
      dc_hit_d = '0;
    end else if (active) begin
      if (ic_req_i) ic_req_d = sat_inc(ic_req_q);
      if (ic_hit_i) ic_hit_d = sat_inc(ic_hit_q);
      if (dc_req_i) dc_req_d = sat_inc(dc_req_q);
      if (dc_hit_i) dc_hit_d = sat_inc(dc_hit_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ic_req_q <= '0;
      ic_hit_q <= '0;
      dc_req_q <= '0;
      dc_hit_q <= '0;
    end else begin
      ic_req_q <= ic_req_d;
      ic_hit_q <= ic_hit_d;
      dc_req_q <= dc_req_d;
      dc_hit_q <= dc_hit_d;
    end
  end

  assign ic_req_cnt_o = ic_req_q;
  assign ic_hit_cnt_o = ic_hit_q;
  assign dc_req_cnt_o = dc_req_q;
  assign dc_hit_cnt_o = dc_hit_q;
`else
  logic unused_cache_strobes;
  assign unused_cache_strobes = ^{ic_req_i, ic_hit_i, dc_req_i, dc_hit_i};

  assign ic_req_cnt_o = '0;
  assign ic_hit_cnt_o = '0;
  assign dc_req_cnt_o = '0;
  assign dc_hit_cnt_o = '0;
`endif

endmodule

// File: tb/tb_retire_trace_buf.sv
// Directed bench for retire_trace_buf: expected records queued at stimulus, checked by a drain-side monitor.
module tb_retire_trace_buf;

  localparam int CNT_W = 32;
`ifdef RETIRE_TRACE_CACHE_STATS_EN
  localparam int EXP_CACHE = 5;
`else
  localparam int EXP_CACHE = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr_i = 1'b0, reg_wr_i = 1'b0, mem_rd_i = 1'b0, mem_wr_i = 1'b0, halt_i = 1'b0;
  logic [2:0]  wr_reg_i = '0;
  logic [15:0] wr_data_i = '0, mem_addr_i = '0, mem_data_i = '0;
  logic ic_req_i = 1'b0, ic_hit_i = 1'b0, dc_req_i = 1'b0, dc_hit_i = 1'b0;
  logic rd_ready_i = 1'b0;
  logic rd_valid_o, halted_o, overflow_o;
  logic [54:0] rd_rec_o;
  logic [CNT_W-1:0] cyc_cnt_o, inst_cnt_o, ic_req_cnt_o, ic_hit_cnt_o, dc_req_cnt_o, dc_hit_cnt_o;

  int errors = 0;
  int checks = 0;
  logic [54:0] exp_q[$];

  retire_trace_buf #(.DEPTH(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr_i(clr_i),
    .reg_wr_i(reg_wr_i), .wr_reg_i(wr_reg_i), .wr_data_i(wr_data_i),
    .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .halt_i(halt_i), .ic_req_i(ic_req_i), .ic_hit_i(ic_hit_i), .dc_req_i(dc_req_i), .dc_hit_i(dc_hit_i),
    .rd_ready_i(rd_ready_i), .rd_valid_o(rd_valid_o), .rd_rec_o(rd_rec_o),
    .cyc_cnt_o(cyc_cnt_o), .inst_cnt_o(inst_cnt_o),
    .ic_req_cnt_o(ic_req_cnt_o), .ic_hit_cnt_o(ic_hit_cnt_o),
    .dc_req_cnt_o(dc_req_cnt_o), .dc_hit_cnt_o(dc_hit_cnt_o),
    .halted_o(halted_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [54:0] mk_rec(input logic h, input logic st, input logic ld, input logic rw,
                                         input logic [2:0] rg, input logic [15:0] wd,
                                         input logic [15:0] a, input logic [15:0] md);
    return {h, st, ld, rw, rg, wd, a, md};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    clr_i = 1'b0; reg_wr_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0; halt_i = 1'b0;
    ic_req_i = 1'b0; ic_hit_i = 1'b0; dc_req_i = 1'b0; dc_hit_i = 1'b0;
  endtask

  task automatic clear_cycle();
    clr_i = 1'b1;
    cyc(1);
    clr_i = 1'b0;
  endtask

  task automatic drain(input string name);
    rd_ready_i = 1'b1;
    for (int k = 0; k < 20 && rd_valid_o; k++) cyc(1);
    rd_ready_i = 1'b0;
    check(name, {63'd0, rd_valid_o}, 64'd0);
  endtask

  // Monitor: every accepted head record must match the oldest expected record.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && rd_valid_o && rd_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %0h expected no record", rd_rec_o);
        end else begin
          check("sb_rec", {9'd0, rd_rec_o}, {9'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    cyc(3);
    check("rst_valid",    {63'd0, rd_valid_o}, 64'd0);
    check("rst_rec",      {9'd0, rd_rec_o}, 64'd0);
    check("rst_cyc",      {32'd0, cyc_cnt_o}, 64'd0);
    check("rst_inst",     {32'd0, inst_cnt_o}, 64'd0);
    check("rst_halted",   {63'd0, halted_o}, 64'd0);
    check("rst_overflow", {63'd0, overflow_o}, 64'd0);
    rst = 1'b1;
    cyc(1);

    // Single record
    reg_wr_i = 1'b1; wr_reg_i = 3'd3; wr_data_i = 16'h1234;
    exp_q.push_back(mk_rec(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h1234, 16'h0, 16'h0));
    cyc(1);
    idle();
    check("single_valid", {63'd0, rd_valid_o}, 64'd1);
    check("single_rec",   {9'd0, rd_rec_o}, {9'd0, mk_rec(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h1234, 16'h0, 16'h0)});
    check("single_inst",  {32'd0, inst_cnt_o}, 64'd1);
    check("single_cyc",   {32'd0, cyc_cnt_o}, 64'd2);
    cyc(1);
    check("hold_rec",     {9'd0, rd_rec_o}, {9'd0, mk_rec(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h1234, 16'h0, 16'h0)});
    rd_ready_i = 1'b1;
    cyc(1);
    rd_ready_i = 1'b0;
    check("single_popped", {63'd0, rd_valid_o}, 64'd0);

    // Combined load + register write
    reg_wr_i = 1'b1; mem_rd_i = 1'b1; wr_reg_i = 3'd5; wr_data_i = 16'hBEEF;
    mem_addr_i = 16'h0040; mem_data_i = 16'hBEEF;
    exp_q.push_back(mk_rec(1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 16'hBEEF, 16'h0040, 16'hBEEF));
    cyc(1);
    idle();
    check("comb_inst", {32'd0, inst_cnt_o}, 64'd2);
    check("comb_cyc",  {32'd0, cyc_cnt_o}, 64'd5);
    drain("comb_drain");

    // Overflow: 9 stores into an 8-deep FIFO, then a 10th with a concurrent pop
    clear_cycle();
    check("clr_cyc", {32'd0, cyc_cnt_o}, 64'd0);
    for (int i = 0; i < 9; i++) begin
      mem_wr_i = 1'b1; wr_reg_i = 3'd7; wr_data_i = 16'hDEAD;
      mem_addr_i = 16'h0100 + 16'(i); mem_data_i = 16'hA000 + 16'(i);
      if (i < 8) exp_q.push_back(mk_rec(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0100 + 16'(i), 16'hA000 + 16'(i)));
      cyc(1);
      if (i == 7) check("ovf_before", {63'd0, overflow_o}, 64'd0);
    end
    idle();
    check("ovf_flag", {63'd0, overflow_o}, 64'd1);
    check("ovf_inst", {32'd0, inst_cnt_o}, 64'd9);
    check("ovf_cyc",  {32'd0, cyc_cnt_o}, 64'd9);
    mem_wr_i = 1'b1; mem_addr_i = 16'h0109; mem_data_i = 16'hA009; rd_ready_i = 1'b1;
    exp_q.push_back(mk_rec(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0109, 16'hA009));
    cyc(1);
    idle();
    rd_ready_i = 1'b0;
    check("ovf_inst10", {32'd0, inst_cnt_o}, 64'd10);
    check("ovf_valid",  {63'd0, rd_valid_o}, 64'd1);
    drain("ovf_drain");

    // Backpressure: ready toggles during 6 pushes; unused fields must read zero
    clear_cycle();
    for (int i = 0; i < 6; i++) begin
      reg_wr_i = 1'b1; wr_reg_i = 3'(i); wr_data_i = 16'h5000 + 16'(i);
      mem_addr_i = 16'hFFFF; mem_data_i = 16'h1111;
      rd_ready_i = (i % 2) == 1;
      exp_q.push_back(mk_rec(1'b0, 1'b0, 1'b0, 1'b1, 3'(i), 16'h5000 + 16'(i), 16'h0, 16'h0));
      cyc(1);
    end
    idle();
    drain("bp_drain");

    // Sustained push + pop
    rd_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_rd_i = 1'b1; mem_addr_i = 16'h0200 + 16'(i); mem_data_i = 16'hC000 + 16'(i);
      exp_q.push_back(mk_rec(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 16'h0200 + 16'(i), 16'hC000 + 16'(i)));
      cyc(1);
    end
    idle();
    drain("sus_drain");
    check("sus_no_ovf", {63'd0, overflow_o}, 64'd0);

    // Cache strobes
    clear_cycle();
    for (int i = 0; i < 5; i++) begin
      ic_req_i = 1'b1; ic_hit_i = 1'b1; dc_req_i = 1'b1; dc_hit_i = 1'b1;
      cyc(1);
      idle();
      cyc(1);
    end
    check("ic_req", {32'd0, ic_req_cnt_o}, 64'(EXP_CACHE));
    check("ic_hit", {32'd0, ic_hit_cnt_o}, 64'(EXP_CACHE));
    check("dc_req", {32'd0, dc_req_cnt_o}, 64'(EXP_CACHE));
    check("dc_hit", {32'd0, dc_hit_cnt_o}, 64'(EXP_CACHE));
    check("cache_inst", {32'd0, inst_cnt_o}, 64'd0);

    // Halt freeze
    clear_cycle();
    reg_wr_i = 1'b1; wr_reg_i = 3'd2; wr_data_i = 16'h0BAD;
    exp_q.push_back(mk_rec(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 16'h0BAD, 16'h0, 16'h0));
    cyc(1);
    idle();
    cyc(18);
    check("pre_halt_cyc", {32'd0, cyc_cnt_o}, 64'd19);
    halt_i = 1'b1;
    exp_q.push_back(mk_rec(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0));
    cyc(1);
    idle();
    check("halted",    {63'd0, halted_o}, 64'd1);
    check("halt_cyc",  {32'd0, cyc_cnt_o}, 64'd20);
    check("halt_inst", {32'd0, inst_cnt_o}, 64'd2);
    reg_wr_i = 1'b1; mem_wr_i = 1'b1; halt_i = 1'b1; ic_req_i = 1'b1; dc_hit_i = 1'b1;
    cyc(3);
    idle();
    check("frz_cyc",  {32'd0, cyc_cnt_o}, 64'd20);
    check("frz_inst", {32'd0, inst_cnt_o}, 64'd2);
    check("frz_ic",   {32'd0, ic_req_cnt_o}, 64'd0);
    drain("halt_drain");
    check("post_drain_cyc", {32'd0, cyc_cnt_o}, 64'd20);
    clear_cycle();
    check("clr_halted", {63'd0, halted_o}, 64'd0);
    check("clr_cyc2",   {32'd0, cyc_cnt_o}, 64'd0);
    check("clr_inst2",  {32'd0, inst_cnt_o}, 64'd0);

    // clr_i beats a same-cycle event
    for (int i = 0; i < 2; i++) begin
      reg_wr_i = 1'b1; wr_reg_i = 3'd1; wr_data_i = 16'h7700 + 16'(i);
      cyc(1);
    end
    idle();
    clr_i = 1'b1; reg_wr_i = 1'b1; mem_wr_i = 1'b1;
    cyc(1);
    idle();
    check("clrpri_valid", {63'd0, rd_valid_o}, 64'd0);
    check("clrpri_inst",  {32'd0, inst_cnt_o}, 64'd0);

    // Asynchronous reset in the middle of a drain
    for (int i = 0; i < 3; i++) begin
      mem_wr_i = 1'b1; mem_addr_i = 16'h0300 + 16'(i); mem_data_i = 16'h0;
      exp_q.push_back(mk_rec(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0300 + 16'(i), 16'h0));
      cyc(1);
    end
    idle();
    rd_ready_i = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("mrst_valid", {63'd0, rd_valid_o}, 64'd0);
    check("mrst_rec",   {9'd0, rd_rec_o}, 64'd0);
    check("mrst_cyc",   {32'd0, cyc_cnt_o}, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rd_ready_i = 1'b0;
    rst = 1'b1;
    cyc(2);
    check("mrst_empty", {63'd0, rd_valid_o}, 64'd0);

    check("sb_all_consumed", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
